// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register with increment, stall, redirect and end-of-memory halt,
// plus the IF/ID pipeline register and a saturating count of valid fetches.
module fetch_stage #(
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          MEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [31:0]          NOP_WORD  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [31:0]       imem_instruction,
    output logic [ADDR_W-1:0] imem_address,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc_next,
    output logic              if_id_valid,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    localparam logic [ADDR_W:0]   DepthW = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(MEM_DEPTH - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [ADDR_W-1:0] id_pc_next_q, id_pc_next_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic [31:0]       count_q, count_d;
    logic              load_valid;

    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        id_pc_d      = id_pc_q;
        id_pc_next_d = id_pc_next_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        load_valid   = 1'b0;

        if (branch_taken) begin
            pc_d     = branch_target;
            instr_d  = NOP_WORD;
            valid_d  = 1'b0;
            halted_d = ({1'b0, branch_target} >= DepthW);
        end else if (stall) begin
            if (flush) begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
        end else if (halted_q) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else begin
            if (flush) begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end else begin
                instr_d      = imem_instruction;
                id_pc_d      = pc_q;
                id_pc_next_d = pc_q + 1'b1;
                valid_d      = 1'b1;
                load_valid   = 1'b1;
            end
            // The last word is fetched normally; the PC then parks on it.
            if (pc_q >= LastPc) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end

        count_d = count_q;
        if (load_valid && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            instr_q      <= NOP_WORD;
            id_pc_q      <= '0;
            id_pc_next_q <= '0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            id_pc_q      <= id_pc_d;
            id_pc_next_q <= id_pc_next_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
            count_q      <= count_d;
        end
    end

    assign imem_address  = pc_q;
    assign if_id_instr   = instr_q;
    assign if_id_pc      = id_pc_q;
    assign if_id_pc_next = id_pc_next_q;
    assign if_id_valid   = valid_q;
    assign halted        = halted_q;
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized control traffic, all checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, flush, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_instruction;
    logic [31:0] imem_address;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_next, fetch_count;
    logic        if_id_valid, halted;

    logic [31:0] mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic [31:0] m_pc, m_instr, m_ipc, m_inext, m_count;
    logic        m_valid, m_halted;

    fetch_stage #(
        .ADDR_W   (32),
        .MEM_DEPTH(DEPTH),
        .RESET_PC (32'd0),
        .NOP_WORD (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_instruction(imem_instruction),
        .imem_address    (imem_address),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_next   (if_id_pc_next),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (imem_address < DEPTH) imem_instruction = mem[imem_address[9:0]];
        else                      imem_instruction = 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the fetch rules, from the bench's current inputs.
    task automatic model_edge();
        if (rst) begin
            m_pc = 0; m_instr = NOP; m_ipc = 0; m_inext = 0;
            m_valid = 0; m_halted = 0; m_count = 0;
        end else if (branch_taken) begin
            m_pc = branch_target; m_instr = NOP; m_valid = 0;
            m_halted = (branch_target >= DEPTH);
        end else if (stall) begin
            if (flush) begin m_instr = NOP; m_valid = 0; end
        end else if (m_halted) begin
            m_instr = NOP; m_valid = 0;
        end else begin
            if (flush) begin
                m_instr = NOP; m_valid = 0;
            end else begin
                m_instr = mem[m_pc[9:0]]; m_ipc = m_pc; m_inext = m_pc + 1; m_valid = 1;
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            end
            if (m_pc == DEPTH - 1) m_halted = 1;
            else                   m_pc = m_pc + 1;
        end
    endtask

    task automatic check_all();
        check("pc",      imem_address,  m_pc);
        check("instr",   if_id_instr,   m_instr);
        check("id_pc",   if_id_pc,      m_ipc);
        check("id_next", if_id_pc_next, m_inext);
        check("valid",   if_id_valid,   m_valid);
        check("halted",  halted,        m_halted);
        check("count",   fetch_count,   m_count);
    endtask

    task automatic cycle();
        check("addr_pre", imem_address, m_pc);
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_in(input logic r, input logic s, input logic f, input logic b,
                          input logic [31:0] t);
        rst = r; stall = s; flush = f; branch_taken = b; branch_target = t;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        set_in(1, 0, 0, 0, 0);
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        check("rst_valid", if_id_valid, 1'b0);
        check("rst_count", fetch_count, 32'd0);

        // Free-running fetch then a two-cycle stall holding pc=2.
        set_in(0, 0, 0, 0, 0);
        repeat (3) cycle();
        check("run_id_pc", if_id_pc, 32'd2);
        check("run_instr", if_id_instr, mem[2]);
        stall = 1;
        repeat (2) cycle();
        check("stall_addr", imem_address, 32'd3);
        check("stall_id_pc", if_id_pc, 32'd2);
        check("stall_count", fetch_count, 32'd3);
        stall = 0;
        cycle();
        check("rel_id_pc", if_id_pc, 32'd3);
        check("rel_next", if_id_pc_next, 32'd4);
        check("rel_count", fetch_count, 32'd4);

        // Redirect overrides a simultaneous stall.
        set_in(0, 1, 0, 1, 32'd10);
        cycle();
        check("br_addr", imem_address, 32'd10);
        check("br_valid", if_id_valid, 1'b0);
        check("br_instr", if_id_instr, NOP);
        set_in(0, 0, 0, 0, 0);
        cycle();
        check("br_id_pc", if_id_pc, 32'd10);
        check("br_fetch", if_id_instr, mem[10]);

        // Flush alone at pc=5.
        set_in(0, 0, 0, 1, 32'd5);
        cycle();
        set_in(0, 0, 1, 0, 0);
        cycle();
        check("fl_addr", imem_address, 32'd6);
        check("fl_valid", if_id_valid, 1'b0);
        flush = 0;
        cycle();
        check("fl_id_pc", if_id_pc, 32'd6);
        check("fl_valid2", if_id_valid, 1'b1);

        // Run off the end of memory, then recover.
        set_in(0, 0, 0, 1, 32'd1022);
        cycle();
        set_in(0, 0, 0, 0, 0);
        cycle();
        cycle();
        check("end_id_pc", if_id_pc, 32'd1023);
        check("end_halt", halted, 1'b1);
        repeat (2) cycle();
        check("end_addr", imem_address, 32'd1023);
        check("end_bubble", if_id_valid, 1'b0);
        set_in(0, 0, 0, 1, 32'd0);
        cycle();
        check("rec_halt", halted, 1'b0);
        set_in(0, 0, 0, 0, 0);
        cycle();
        check("rec_id_pc", if_id_pc, 32'd0);
        check("rec_valid", if_id_valid, 1'b1);
        set_in(0, 0, 0, 1, 32'd2000);
        cycle();
        check("oor_halt", halted, 1'b1);
        set_in(0, 0, 0, 0, 0);
        cycle();
        check("oor_addr", imem_address, 32'd2000);
        check("oor_valid", if_id_valid, 1'b0);

        // Reset during a stall.
        set_in(1, 0, 0, 0, 0);
        cycle();
        rst = 0;
        repeat (7) cycle();
        check("pre_count", fetch_count, 32'd7);
        set_in(1, 1, 0, 0, 0);
        cycle();
        check("rs_addr", imem_address, 32'd0);
        check("rs_count", fetch_count, 32'd0);
        check("rs_valid", if_id_valid, 1'b0);
        check("rs_halt", halted, 1'b0);

        // Randomized control traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 6)      tgt = $urandom_range(0, DEPTH - 1);
            else if (sel == 7) tgt = $urandom_range(DEPTH - 6, DEPTH - 1);
            else if (sel == 8) tgt = $urandom_range(DEPTH, DEPTH + 80);
            else               tgt = $urandom;
            set_in(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
                   ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8), tgt);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that drives the word address of the instruction memory and captures the returned word into the IF/ID pipeline register. It holds the PC register with sequential increment, stall, branch redirect and end-of-program halt. It also keeps a retired-fetch counter for test benches.
The memory is word-indexed (entry n at address n), so the PC advances by 1 per instruction. The memory read is combinational and settles within one clock period.

Parameters:
ADDR_W, 32, width of PC and memory address
MEM_DEPTH, 1024, number of instruction words; valid PCs are 0..MEM_DEPTH-1
RESET_PC, 0, PC value loaded on reset
NOP_WORD, 32'h00000000, instruction value injected for bubbles

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard stall from decode; holds PC and IF/ID
flush  in  1  squash IF/ID contents (bubble) without redirect
branch_taken  in  1  redirect request from execute stage
branch_target  in  ADDR_W  word address to redirect to
imem_instruction  in  32  word returned by instruction memory for imem_address
imem_address  out  ADDR_W  current PC, driven combinationally from PC register
if_id_instr  out  32  latched instruction
if_id_pc  out  ADDR_W  PC of latched instruction
if_id_pc_next  out  ADDR_W  if_id_pc + 1
if_id_valid  out  1  IF/ID holds a real instruction
halted  out  1  PC ran past MEM_DEPTH-1; fetch stopped
fetch_count  out  32  number of instructions latched valid into IF/ID

Behaviour:
- Reset (rst=1 at edge) has priority over everything:
  - PC=RESET_PC; if_id_instr=NOP_WORD; if_id_pc=0; if_id_pc_next=0; if_id_valid=0; halted=0; fetch_count=0.
  - A reset asserted mid-stall or mid-redirect discards that pending event.
- imem_address = PC, with no register in between. The instruction for PC appears in IF/ID one edge later (1-cycle fetch latency).
- Per-edge priority, highest first: rst, branch_taken, stall, halted, normal.
- branch_taken=1:
  - PC<=branch_target.
  - IF/ID loaded with a bubble: if_id_instr=NOP_WORD, if_id_valid=0, if_id_pc and if_id_pc_next unchanged.
  - halted<=0 if branch_target < MEM_DEPTH, else halted<=1.
  - branch_taken overrides a simultaneous stall.
- stall=1, branch_taken=0: PC and all IF/ID outputs hold. If flush is also 1, if_id_valid<=0 and if_id_instr<=NOP_WORD, PC still holds.
- flush=1, stall=0, branch_taken=0: PC advances normally, but IF/ID takes a bubble instead of imem_instruction.
- Normal advance (not halted):
  - IF/ID<={imem_instruction, PC, PC+1, valid=1}.
  - If PC == MEM_DEPTH-1, set halted<=1 and leave PC at MEM_DEPTH-1. The last word is still latched valid.
  - Otherwise PC<=PC+1.
- halted=1 without redirect: PC holds and IF/ID loads bubbles each cycle. Only rst or branch_taken leaves halt.
- fetch_count increments by 1 on every edge where if_id_valid is written 1. It saturates at 32'hFFFFFFFF.
- PC arithmetic is ADDR_W-bit unsigned. branch_target >= MEM_DEPTH loads PC and sets halted immediately, with no fetch from the out-of-range address.
- Outputs never show X after the first reset edge.

Test Plan:
- Reset then 4 free-running cycles with memory[0..3]=A,B,C,D -> if_id_instr A,B,C,D on successive edges; if_id_pc 0,1,2,3; if_id_pc_next 1,2,3,4; valid=1; fetch_count=4.
- Stall high 2 cycles while IF/ID holds instr at pc=2 -> imem_address stays 3; if_id_pc stays 2; fetch_count unchanged. After release the next edge latches pc=3.
- branch_taken=1, branch_target=10, with stall=1 in the same cycle -> next edge PC=10, if_id_valid=0, if_id_instr=0. The following edge latches memory[10] with if_id_pc=10.
- flush=1 alone at PC=5 -> IF/ID bubble and PC=6. The next edge latches memory[6] valid.
- Branch to 1022, run 4 cycles -> words 1022 and 1023 latched valid, halted=1, PC stays 1023, and bubbles follow. Then branch_target=0 clears halted and fetch resumes. A separate case with branch_target=2000 sets halted at once with no valid fetch.
- Assert rst during a stall with fetch_count=7 -> next edge PC=0, fetch_count=0, if_id_valid=0, halted=0.
